// File: rtl/stack_exec_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stack_exec_seq_if                                                         |
// | Command handshake and completion bundle for the stack execute sequencer.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
interface stack_exec_seq_if #(
  parameter int DW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [DW-1:0] cmd_imm;
  logic          done;
  logic          err;
  logic          err_ovf;
  logic [DW-1:0] result;

  modport master (
    output cmd_valid, cmd_op, cmd_imm,
    input  cmd_ready, done, err, err_ovf, result
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_imm,
    output cmd_ready, done, err, err_ovf, result
  );
endinterface
`default_nettype wire

// File: rtl/stack_exec_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stack_exec_seq                                                            |
// | Sole master of the data stack: pops operands, runs the ALU, pushes the    |
// | result back and guards against under/overflow. Optional Z/C flags are     |
// | built when STACK_EXEC_SEQ_FLAGS_EN is defined.                            |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module stack_exec_seq #(
  parameter int DW    = 8,
  parameter int DEPTH = 256
) (
  input  wire                    clk,
  input  wire                    rst,
  stack_exec_seq_if.slave        cmd,
  output logic                   stk_push,
  output logic                   stk_pop,
  output logic                   stk_tos,
  output logic [DW-1:0]          stk_d_in,
  input  wire  [DW-1:0]          stk_d_out,
  output logic [$clog2(DEPTH):0] depth
`ifdef STACK_EXEC_SEQ_FLAGS_EN
  ,
  output logic                   flag_z,
  output logic                   flag_c
`endif
);

  localparam int AW = $clog2(DEPTH) + 1;

  localparam logic [AW-1:0] c_full = AW'(DEPTH);
  localparam logic [AW-1:0] c_one  = AW'(1);
  localparam logic [AW-1:0] c_two  = AW'(2);

  localparam logic [2:0] c_op_push = 3'b000;
  localparam logic [2:0] c_op_pop  = 3'b001;
  localparam logic [2:0] c_op_add  = 3'b010;
  localparam logic [2:0] c_op_sub  = 3'b011;
  localparam logic [2:0] c_op_and  = 3'b100;
  localparam logic [2:0] c_op_or   = 3'b101;
  localparam logic [2:0] c_op_not  = 3'b110;
  localparam logic [2:0] c_op_dup  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_POPA = 3'd1,
    S_POPB = 3'd2,
    S_TOSA = 3'd3,
    S_EXEC = 3'd4,
    S_WB   = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [DW-1:0] imm_q, imm_d;
  logic [DW-1:0] opa_q, opa_d;
  logic [DW-1:0] result_q, result_d;
  logic [AW-1:0] depth_q, depth_d;
  logic          ovf_q, ovf_d;

  logic          w_ready;
  logic          w_done;
  logic          w_err;
  logic          w_err_ovf;

  // Legality of the incoming command against the pre-command occupancy
  logic          w_need1;
  logic          w_need2;
  logic          w_need_room;
  logic          w_udf;
  logic          w_ovf;

  always_comb begin
    w_need1     = (cmd.cmd_op == c_op_pop) || (cmd.cmd_op == c_op_not) ||
                  (cmd.cmd_op == c_op_dup);
    w_need2     = (cmd.cmd_op == c_op_add) || (cmd.cmd_op == c_op_sub) ||
                  (cmd.cmd_op == c_op_and) || (cmd.cmd_op == c_op_or);
    w_need_room = (cmd.cmd_op == c_op_push) || (cmd.cmd_op == c_op_dup);
    w_udf       = (w_need1 && (depth_q == '0)) || (w_need2 && (depth_q < c_two));
    w_ovf       = w_need_room && (depth_q == c_full);
  end

  logic w_op_binary;
  assign w_op_binary = (op_q == c_op_add) || (op_q == c_op_sub) ||
                       (op_q == c_op_and) || (op_q == c_op_or);

  // ALU: x is the freshly read stack word, opA the earlier-popped top
  logic [DW:0]   w_wide;
  logic [DW-1:0] w_alu;
  logic          w_carry;

  always_comb begin
    w_wide  = '0;
    w_alu   = stk_d_out;
    w_carry = 1'b0;
    case (op_q)
      c_op_add: begin
        w_wide  = {1'b0, stk_d_out} + {1'b0, opa_q};
        w_alu   = w_wide[DW-1:0];
        w_carry = w_wide[DW];
      end
      c_op_sub: begin
        w_wide  = {1'b0, stk_d_out} - {1'b0, opa_q};
        w_alu   = w_wide[DW-1:0];
        w_carry = w_wide[DW];
      end
      c_op_and: w_alu = stk_d_out & opa_q;
      c_op_or:  w_alu = stk_d_out | opa_q;
      c_op_not: w_alu = ~stk_d_out;
      default:  w_alu = stk_d_out;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    imm_d     = imm_q;
    opa_d     = opa_q;
    result_d  = result_q;
    depth_d   = depth_q;
    ovf_d     = ovf_q;
    w_ready   = 1'b0;
    w_done    = 1'b0;
    w_err     = 1'b0;
    w_err_ovf = 1'b0;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_tos   = 1'b0;
    stk_d_in  = '0;

    case (state_q)
      S_IDLE: begin
        w_ready = 1'b1;
        if (cmd.cmd_valid) begin
          op_d  = cmd.cmd_op;
          imm_d = cmd.cmd_imm;
          if (w_udf || w_ovf) begin
            ovf_d   = w_ovf && !w_udf;
            state_d = S_ERR;
          end else if (cmd.cmd_op == c_op_push) begin
            state_d = S_WB;
          end else if (cmd.cmd_op == c_op_dup) begin
            state_d = S_TOSA;
          end else begin
            state_d = S_POPA;
          end
        end
      end

      S_POPA: begin
        stk_pop = 1'b1;
        depth_d = depth_q - c_one;
        state_d = w_op_binary ? S_POPB : S_EXEC;
      end

      // The word popped in POPA has landed on stk_d_out: it is the old top
      S_POPB: begin
        stk_pop = 1'b1;
        depth_d = depth_q - c_one;
        opa_d   = stk_d_out;
        state_d = S_EXEC;
      end

      S_TOSA: begin
        stk_tos = 1'b1;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        result_d = w_alu;
        state_d  = S_WB;
      end

      S_WB: begin
        w_done = 1'b1;
        if (op_q == c_op_push) begin
          result_d = imm_q;
          stk_push = 1'b1;
          stk_d_in = imm_q;
          depth_d  = depth_q + c_one;
        end else if (op_q != c_op_pop) begin
          stk_push = 1'b1;
          stk_d_in = result_q;
          depth_d  = depth_q + c_one;
        end
        state_d = S_IDLE;
      end

      S_ERR: begin
        w_done    = 1'b1;
        w_err     = 1'b1;
        w_err_ovf = ovf_q;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      imm_q    <= '0;
      opa_q    <= '0;
      result_q <= '0;
      depth_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      imm_q    <= imm_d;
      opa_q    <= opa_d;
      result_q <= result_d;
      depth_q  <= depth_d;
      ovf_q    <= ovf_d;
    end
  end

  assign cmd.cmd_ready = w_ready;
  assign cmd.done      = w_done;
  assign cmd.err       = w_err;
  assign cmd.err_ovf   = w_err_ovf;
  assign cmd.result    = result_q;
  assign depth         = depth_q;

`ifdef STACK_EXEC_SEQ_FLAGS_EN
  logic flag_z_q, flag_z_d;
  logic flag_c_q, flag_c_d;

  // Flags only move with a computed result; PUSH and rejected commands never reach EXEC
  always_comb begin
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    if (state_q == S_EXEC) begin
      flag_z_d = (w_alu == '0);
      flag_c_d = w_carry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
    end
  end

  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;
`else
  logic w_unused_carry;
  assign w_unused_carry = w_carry;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stack_exec_seq.sv
`default_nettype none
// Randomized and directed bench for stack_exec_seq with a bench-side stack
// and a command-level reference model (a byte queue).
module tb_stack_exec_seq;
  localparam int DW    = 8;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stack_exec_seq_if #(.DW(DW)) bus();

  logic          stk_push, stk_pop, stk_tos;
  logic [DW-1:0] stk_d_in, stk_d_out;
  logic [8:0]    depth;
`ifdef STACK_EXEC_SEQ_FLAGS_EN
  logic          flag_z, flag_c;
`endif

  stack_exec_seq #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (bus),
    .stk_push  (stk_push),
    .stk_pop   (stk_pop),
    .stk_tos   (stk_tos),
    .stk_d_in  (stk_d_in),
    .stk_d_out (stk_d_out),
    .depth     (depth)
`ifdef STACK_EXEC_SEQ_FLAGS_EN
    ,
    .flag_z    (flag_z),
    .flag_c    (flag_c)
`endif
  );

  // Bench-side data stack: 8-bit wrapping pointer, registered read port
  logic [7:0] smem [0:255];
  logic [7:0] sp;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp        <= 8'd0;
      stk_d_out <= '0;
    end else if (stk_push) begin
      smem[sp] <= stk_d_in;
      sp       <= sp + 8'd1;
    end else if (stk_pop) begin
      stk_d_out <= smem[sp - 8'd1];
      sp        <= sp - 8'd1;
    end else if (stk_tos) begin
      stk_d_out <= smem[sp - 8'd1];
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model state (committed after each command completes)
  byte unsigned mq[$];
  logic [7:0]   m_result = 8'h00;
  bit           m_z = 1'b0, m_c = 1'b0;

  // In-flight command expectations
  bit busy = 1'b0;
  int acc_cyc = 0, lat = 0;
  bit p_err, p_ovf;
  int e_pop, e_tos, e_push;
  int n_pop, n_tos, n_push;
  int last_done_cyc = 0;
  bit last_err, last_ovf;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_ready", bus.cmd_ready, 1);
      check("rst_done", bus.done, 0);
      check("rst_depth", depth, 0);
      check("rst_result", bus.result, 0);
      check("rst_strobes", {stk_push, stk_pop, stk_tos}, 0);
    end else begin
      check("one_strobe", ((int'(stk_push) + int'(stk_pop) + int'(stk_tos)) <= 1), 1);
      if (!stk_push) check("d_in_zero", stk_d_in, 0);
      if (!busy || cyc <= acc_cyc) begin
        n_pop = 0; n_tos = 0; n_push = 0;
        check("idle_ready", bus.cmd_ready, 1);
        check("idle_done", bus.done, 0);
        check("idle_depth", depth, mq.size());
        check("idle_result", bus.result, m_result);
        check("idle_strobes", {stk_push, stk_pop, stk_tos}, 0);
`ifdef STACK_EXEC_SEQ_FLAGS_EN
        check("idle_flag_z", flag_z, m_z);
        check("idle_flag_c", flag_c, m_c);
`endif
      end else begin
        n_pop  += int'(stk_pop);
        n_tos  += int'(stk_tos);
        n_push += int'(stk_push);
        check("busy_ready", bus.cmd_ready, 0);
        if (cyc < acc_cyc + lat) begin
          check("early_done", bus.done, 0);
        end else if (cyc == acc_cyc + lat) begin
          check("done", bus.done, 1);
          check("err", bus.err, p_err);
          if (p_err) check("err_ovf", bus.err_ovf, p_ovf);
          check("n_pop", n_pop, e_pop);
          check("n_tos", n_tos, e_tos);
          check("n_push", n_push, e_push);
          last_done_cyc = cyc;
          last_err      = bus.err;
          last_ovf      = bus.err_ovf;
        end
      end
    end
  end

  task automatic do_reset();
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    mq.delete();
    m_result = 8'h00; m_z = 1'b0; m_c = 1'b0;
    busy = 1'b0;
    #1;
    check("reset_ready", bus.cmd_ready, 1);
    check("reset_depth", depth, 0);
    check("reset_result", bus.result, 0);
    check("reset_strobes", {stk_push, stk_pop, stk_tos, bus.done}, 0);
`ifdef STACK_EXEC_SEQ_FLAGS_EN
    check("reset_flags", {flag_z, flag_c}, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Called 1 time unit after a posedge with the DUT idle; returns likewise.
  task automatic run_cmd(input logic [2:0] op, input logic [7:0] imm,
                         input bit junk, input int abort_at);
    int D, need, sum;
    bit udf, ovf;
    byte unsigned t, s, r;
    D    = mq.size();
    need = (op == 3'd0) ? 0 : (op == 3'd1 || op == 3'd6 || op == 3'd7) ? 1 : 2;
    udf  = D < need;
    ovf  = (op == 3'd0 || op == 3'd7) && (D == DEPTH);
    p_err  = udf || ovf;
    p_ovf  = ovf && !udf;
    lat    = p_err ? 1 : (op == 3'd0) ? 1 : (need == 2) ? 4 : 3;
    e_pop  = (p_err || op == 3'd0 || op == 3'd7) ? 0 : need;
    e_tos  = (!p_err && op == 3'd7) ? 1 : 0;
    e_push = (!p_err && op != 3'd1) ? 1 : 0;
    acc_cyc = cyc;
    busy    = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_imm   = imm;
    do begin
      @(posedge clk); #1;
      if (abort_at != 0 && cyc == acc_cyc + abort_at) begin
        check("abort_pop_strobe", stk_pop, 1);
        do_reset();
        return;
      end
      if (junk && cyc < acc_cyc + lat) begin
        bus.cmd_op  = 3'($urandom);
        bus.cmd_imm = 8'($urandom);
      end else begin
        bus.cmd_valid = 1'b0;
      end
    end while (cyc < acc_cyc + lat);
    @(posedge clk); #1;
    if (!p_err) begin
      case (op)
        3'd0: begin mq.push_back(imm); m_result = imm; end
        3'd1: begin
          t = mq.pop_back(); m_result = t; m_z = (t == 0); m_c = 1'b0;
        end
        3'd6: begin
          t = mq.pop_back(); r = ~t; mq.push_back(r);
          m_result = r; m_z = (r == 0); m_c = 1'b0;
        end
        3'd7: begin
          t = mq[$]; mq.push_back(t); m_result = t; m_z = (t == 0); m_c = 1'b0;
        end
        default: begin
          t = mq.pop_back();
          s = mq.pop_back();
          case (op)
            3'd2: begin sum = int'(s) + int'(t); r = 8'(sum); m_c = sum > 255; end
            3'd3: begin r = s - t; m_c = s < t; end
            3'd4: begin r = s & t; m_c = 1'b0; end
            default: begin r = s | t; m_c = 1'b0; end
          endcase
          mq.push_back(r); m_result = r; m_z = (r == 0);
        end
      endcase
    end
    busy = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] last_imm;
    int unsigned rv;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_imm   = 8'h00;
    @(posedge clk); #1;
    do_reset();

    // 5 - 3 = 2
    run_cmd(3'd0, 8'h05, 0, 0);
    run_cmd(3'd0, 8'h03, 0, 0);
    run_cmd(3'd3, 8'h00, 1, 0);
    check("sub_result", bus.result, 8'h02);
    check("sub_depth", depth, 1);
    check("sub_latency", last_done_cyc - acc_cyc, 4);
    check("sub_stack0", smem[0], 8'h02);

    // 0xF0 + 0x20 wraps to 0x10 with carry
    do_reset();
    run_cmd(3'd0, 8'hF0, 0, 0);
    run_cmd(3'd0, 8'h20, 0, 0);
    run_cmd(3'd2, 8'h00, 0, 0);
    check("add_result", bus.result, 8'h10);
    check("add_depth", depth, 1);
`ifdef STACK_EXEC_SEQ_FLAGS_EN
    check("add_flag_c", flag_c, 1);
    check("add_flag_z", flag_z, 0);
`endif

    // POP on an empty stack is an underflow
    do_reset();
    run_cmd(3'd1, 8'h00, 0, 0);
    check("udf_err", last_err, 1);
    check("udf_ovf", last_ovf, 0);
    check("udf_latency", last_done_cyc - acc_cyc, 1);
    check("udf_depth", depth, 0);

    // DUP then AND
    do_reset();
    run_cmd(3'd0, 8'h3C, 0, 0);
    run_cmd(3'd7, 8'h00, 0, 0);
    check("dup_latency", last_done_cyc - acc_cyc, 3);
    run_cmd(3'd4, 8'h00, 0, 0);
    check("and_result", bus.result, 8'h3C);
    check("and_depth", depth, 1);

    // Fill, overflow, then NOT on a full stack
    do_reset();
    last_imm = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      last_imm = 8'($urandom);
      run_cmd(3'd0, last_imm, 0, 0);
    end
    check("full_depth", depth, 256);
    run_cmd(3'd0, 8'h01, 0, 0);
    check("ovf_err", last_err, 1);
    check("ovf_flag", last_ovf, 1);
    check("ovf_depth", depth, 256);
    run_cmd(3'd6, 8'h00, 0, 0);
    check("not_result", bus.result, {24'h0, ~last_imm});
    check("not_depth", depth, 256);

    // Reset during POPB of an ADD, then recover
    do_reset();
    run_cmd(3'd0, 8'h11, 0, 0);
    run_cmd(3'd0, 8'h22, 0, 0);
    run_cmd(3'd2, 8'h00, 0, 2);
    run_cmd(3'd0, 8'h07, 0, 0);
    run_cmd(3'd1, 8'h00, 0, 0);
    check("recover_result", bus.result, 8'h07);
    check("recover_depth", depth, 0);

    // Randomized command stream
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rv = $urandom_range(0, 11);
      run_cmd((rv > 7) ? 3'd0 : 3'(rv), 8'($urandom), bit'($urandom_range(0, 1)), 0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/stack_exec_seq.md
Name: stack_exec_seq

Overview:
- Execute sequencer that sits directly upstream of the 8-bit data stack and is its only master. It owns the stack's push/pop/tos/d_in controls and consumes its registered d_out.
- Accepts one stack-machine command at a time over a valid/ready handshake. It pops operands, computes the ALU result, pushes it back and reports completion.
- Tracks stack occupancy itself and rejects any command that would underflow or overflow the stack, because the stack pointer wraps silently.

Parameters:
DW, 8, data width; must equal the stack data width.
DEPTH, 256, stack capacity in entries; must equal the stack size.

Ports:
clk  in  1  clock
rst  in  1  reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command (high only in IDLE)
cmd_op  in  3  opcode: 000 PUSH, 001 POP, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 NOT, 111 DUP
cmd_imm  in  DW  immediate for PUSH
stk_push  out  1  to stack push
stk_pop  out  1  to stack pop
stk_tos  out  1  to stack tos
stk_d_in  out  DW  to stack d_in
stk_d_out  in  DW  from stack d_out; registered, valid the cycle after pop/tos
done  out  1  one-cycle completion pulse
err  out  1  with done: command rejected
err_ovf  out  1  with err: 1 = overflow, 0 = underflow
result  out  DW  last computed or popped value, held
depth  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. During reset: state IDLE, depth=0, result=0, all outputs 0 except cmd_ready=1. rst mid-command aborts immediately. The stack shares rst, so its pointer also returns to 0.
- Accept: a command is accepted on a clk edge where cmd_valid && cmd_ready. At accept, cmd_op and cmd_imm are latched.
- Legality check at accept uses pre-command depth D:
  - POP, NOT and DUP need D>=1; ADD, SUB, AND and OR need D>=2. Otherwise underflow.
  - PUSH and DUP need D<DEPTH. Otherwise overflow.
  - On a violation go to state ERR for one cycle: done=1, err=1, err_ovf set accordingly. No stack strobes are issued; depth and result are unchanged.
- FSM states: IDLE, POPA, POPB, TOSA, EXEC, WB, ERR. At most one of stk_push, stk_pop, stk_tos is high in any cycle.
- State paths:
  - PUSH: IDLE -> WB.
  - POP and NOT: IDLE -> POPA -> EXEC -> WB.
  - ADD, SUB, AND, OR: IDLE -> POPA -> POPB -> EXEC -> WB.
  - DUP: IDLE -> TOSA -> EXEC -> WB.
  - ERR and WB both return to IDLE.
- POPA: stk_pop=1; depth decrements at the end of the cycle.
- POPB: stk_pop=1; depth decrements; register opA <= stk_d_out (the former top).
- TOSA: stk_tos=1.
- EXEC: no strobes. With x = stk_d_out, register result as follows:
  - POP: x.
  - NOT: ~x.
  - DUP: x.
  - ADD: x+opA, mod 2^DW.
  - SUB: x-opA, mod 2^DW; this is second-from-top minus top.
  - AND: x&opA.
  - OR: x|opA.
- WB:
  - done=1.
  - For PUSH, result <= cmd_imm and the registered imm is pushed.
  - For every op except POP: stk_push=1 and stk_d_in = the result register (or the imm for PUSH); depth increments.
- Latency from accept edge to done cycle: PUSH 1, POP/NOT/DUP 3, binary ops 4, ERR 1. cmd_ready returns high the cycle after done.
- stk_d_in is 0 whenever stk_push=0.
- depth never exceeds DEPTH and never wraps.
- cmd_valid held high while cmd_ready=0 is ignored; there is no queueing.

Optional Feature:
- STACK_EXEC_SEQ_FLAGS_EN defined:
  - Adds outputs flag_z (1 bit) and flag_c (1 bit), both registered in EXEC and reset to 0.
  - flag_z = (new result == 0).
  - flag_c = carry out for ADD, borrow for SUB (x<opA), 0 for every other op.
  - Flags are unchanged on ERR and PUSH.
- Macro undefined: the ports are absent and there is no flag logic.

Test Plan:
- Reset, PUSH 0x05, PUSH 0x03, SUB -> result=0x02, depth=1, done 4 cycles after the SUB accept; stack entry 0 = 0x02.
- PUSH 0xF0, PUSH 0x20, ADD -> result=0x10, depth=1; with FLAGS_EN, flag_c=1 and flag_z=0.
- Empty stack, POP -> done=1, err=1, err_ovf=0 one cycle after accept; no stk_pop pulse; depth=0.
- PUSH 0x3C, DUP, AND -> result=0x3C, depth=1; DUP issues stk_tos (never stk_pop).
- Fill to DEPTH with 256 PUSHes, then PUSH 0x01 -> err=1, err_ovf=1, depth=256. Then NOT -> result = ~(top), depth=256.
- Assert rst during POPB of an ADD -> next cycle cmd_ready=1, depth=0, result=0, no strobes. A following PUSH 0x07 then POP -> result=0x07.
